// File: rtl/trigger_detect.sv
// Edge trigger for the oscilloscope stage: hysteresis arming, stretched fire pulse, holdoff and fire counter.
// Define TRIGGER_AUTO_EN to build in the auto-fire timeout path.
module trigger_detect #(
  parameter int HYST           = 4,
  parameter int HOLDOFF_CYCLES = 160,
  parameter int STRETCH        = 4,
  parameter int AUTO_TIMEOUT   = 625000
) (
  input  logic       clk_62_5,
  input  logic       rst,
  input  logic [7:0] in_y,
  input  logic [7:0] level,
  input  logic       slope_sel,
  input  logic       arm,
  output logic       trigger,
  output logic       auto_fired,
  output logic [7:0] trig_count
);

  typedef enum logic [2:0] {
    IDLE,
    ARMING,
    READY,
    FIRE,
    HOLDOFF
  } state_t;

  localparam int PHASE_MAX = (HOLDOFF_CYCLES > STRETCH) ? HOLDOFF_CYCLES : STRETCH;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] STRETCH_LAST = PW'(STRETCH - 1);
  localparam logic [PW-1:0] HOLD_LAST = PW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
  localparam logic [8:0] HYST9 = 9'(HYST);

  state_t state, next_state;

  logic [7:0]    sample_q;
  logic [7:0]    level_q;
  logic          slope_q;
  logic          hit_q;
  logic [PW-1:0] phase_cnt;
  logic [8:0]    lvl9;
  logic [8:0]    lo_thr;
  logic [8:0]    hi_sum;
  logic [8:0]    hi_thr;
  logic          below_band;
  logic          crossing;
  logic          timeout_hit;
  logic          enter_fire;
  logic          enter_arming;

  // Hysteresis band edges, saturated to the 8-bit code range.
  always_comb begin
    lvl9       = {1'b0, level_q};
    lo_thr     = (lvl9 > HYST9) ? lvl9 - HYST9 : 9'd0;
    hi_sum     = lvl9 + HYST9;
    hi_thr     = (hi_sum > 9'd255) ? 9'd255 : hi_sum;
    below_band = slope_q ? ({1'b0, sample_q} > hi_thr) : ({1'b0, sample_q} < lo_thr);
    crossing   = slope_q ? (sample_q <= level_q) : (sample_q >= level_q);
  end

  always_comb begin
    next_state = state;
    if (!arm) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = ARMING;
        ARMING: begin
          if (timeout_hit)     next_state = FIRE;
          else if (below_band) next_state = READY;
        end
        READY: begin
          if (hit_q || timeout_hit) next_state = FIRE;
        end
        FIRE: begin
          if (phase_cnt == STRETCH_LAST)
            next_state = (HOLDOFF_CYCLES == 0) ? ARMING : HOLDOFF;
        end
        HOLDOFF: begin
          if (phase_cnt == HOLD_LAST) next_state = ARMING;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign enter_fire   = (next_state == FIRE) && (state != FIRE);
  assign enter_arming = (next_state == ARMING) && (state != ARMING);

  always_ff @(posedge clk_62_5 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // hit_q adds the pipeline stage that puts trigger two edges after the crossing sample.
  always_ff @(posedge clk_62_5 or posedge rst) begin
    if (rst) begin
      sample_q   <= 8'd0;
      hit_q      <= 1'b0;
      level_q    <= 8'd0;
      slope_q    <= 1'b0;
      phase_cnt  <= '0;
      trigger    <= 1'b0;
      trig_count <= 8'd0;
    end else begin
      sample_q <= in_y;
      hit_q    <= crossing;
      trigger  <= (next_state == FIRE);
      if (enter_arming) begin
        level_q <= level;
        slope_q <= slope_sel;
      end
      if (next_state != state) phase_cnt <= '0;
      else                     phase_cnt <= phase_cnt + 1'b1;
      if (enter_fire) trig_count <= trig_count + 8'd1;
    end
  end

`ifdef TRIGGER_AUTO_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);

  logic [TW-1:0] timeout_cnt;

  assign timeout_hit = ((state == ARMING) || (state == READY)) &&
                       (timeout_cnt == TW'(AUTO_TIMEOUT - 1));

  always_ff @(posedge clk_62_5 or posedge rst) begin
    if (rst)                                        timeout_cnt <= '0;
    else if (enter_arming)                          timeout_cnt <= '0;
    else if ((state == ARMING) || (state == READY)) timeout_cnt <= timeout_cnt + 1'b1;
  end

  // A genuine crossing in READY takes precedence, so only non-crossing entries are automatic.
  always_ff @(posedge clk_62_5 or posedge rst) begin
    if (rst)                     auto_fired <= 1'b0;
    else if (enter_fire)         auto_fired <= !((state == READY) && hit_q);
    else if (next_state != FIRE) auto_fired <= 1'b0;
  end
`else
  // Timeout path compiled out; AUTO_TIMEOUT is never negative, so this is constant low.
  assign timeout_hit = (AUTO_TIMEOUT < 0);
  assign auto_fired  = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_detect.sv
// Randomized and directed bench for trigger_detect, checked against a timeline model of the trigger rules.
// Honours TRIGGER_AUTO_EN in the same way as the design.
module tb_trigger_detect;

  localparam int HYST = 4;
  localparam int HOLD = 160;
  localparam int STR  = 4;
  localparam int TMO  = 1000;
  localparam int MAXN = 2400;

`ifdef TRIGGER_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic       clk_62_5 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_y = 8'd0;
  logic [7:0] level = 8'd0;
  logic       slope_sel = 1'b0;
  logic       arm = 1'b0;
  logic       trigger;
  logic       auto_fired;
  logic [7:0] trig_count;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  logic [7:0] s_y[MAXN];
  logic [7:0] s_lvl[MAXN];
  logic       s_slope[MAXN];
  logic       s_arm[MAXN];
  logic       got_trig[MAXN];
  logic       got_auto[MAXN];
  logic [7:0] got_cnt[MAXN];
  logic       exp_trig[MAXN];
  logic       exp_auto[MAXN];
  logic [7:0] exp_cnt[MAXN];

  trigger_detect #(
    .HYST(HYST),
    .HOLDOFF_CYCLES(HOLD),
    .STRETCH(STR),
    .AUTO_TIMEOUT(TMO)
  ) dut (
    .clk_62_5(clk_62_5),
    .rst(rst),
    .in_y(in_y),
    .level(level),
    .slope_sel(slope_sel),
    .arm(arm),
    .trigger(trigger),
    .auto_fired(auto_fired),
    .trig_count(trig_count)
  );

  always #8 clk_62_5 = ~clk_62_5;

  function automatic bit leaves_band(int y, int lvl, bit falling);
    return falling ? (y > lvl + HYST) : (y < lvl - HYST);
  endfunction

  function automatic bit is_crossing(int y, int lvl, bit falling);
    return falling ? (y <= lvl) : (y >= lvl);
  endfunction

  // Entry k holds the inputs seen at edge k and the outputs just after it.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      in_y      = s_y[k];
      level     = s_lvl[k];
      slope_sel = s_slope[k];
      arm       = s_arm[k];
      @(posedge clk_62_5);
      #1;
      got_trig[k] = trigger;
      got_auto[k] = auto_fired;
      got_cnt[k]  = trig_count;
    end
  endtask

  // Expected timeline: arm at edge e, qualify on sample a, fire two edges after a later crossing
  // (or at e+TMO), stay high STR edges, stay dead HOLD edges, then re-arm; arm low aborts anywhere.
  task automatic model_run(input int n);
    int k, e, a, f, lvl;
    bit falling, is_auto, aborted;
    logic [7:0] cnt;
    cnt = 8'(model_cnt);
    for (int i = 0; i < n; i++) begin
      exp_trig[i] = 1'b0;
      exp_auto[i] = 1'b0;
      exp_cnt[i]  = 8'd0;
    end
    k = 0;
    while (k < n) begin
      if (!s_arm[k]) begin
        exp_cnt[k] = cnt;
        k++;
        continue;
      end
      e = k;
      lvl = int'(s_lvl[k]);
      falling = s_slope[k];
      exp_cnt[k] = cnt;
      k++;
      a = -1;
      f = -1;
      aborted = 1'b0;
      is_auto = 1'b0;
      while (k < n && f < 0 && !aborted) begin
        if (!s_arm[k]) begin
          aborted = 1'b1;
          exp_cnt[k] = cnt;
          k++;
        end else if (a >= 0 && k - 2 > a && is_crossing(int'(s_y[k-2]), lvl, falling)) begin
          f = k;
        end else if (AUTO_EN && (k - e == TMO)) begin
          f = k;
          is_auto = 1'b1;
        end else begin
          if (a < 0 && leaves_band(int'(s_y[k-1]), lvl, falling)) a = k - 1;
          exp_cnt[k] = cnt;
          k++;
        end
      end
      if (f < 0) continue;
      cnt++;
      for (int j = 0; j < STR + HOLD && k < n; j++) begin
        if (!s_arm[k]) begin
          exp_cnt[k] = cnt;
          k++;
          break;
        end
        exp_trig[k] = (j < STR);
        exp_auto[k] = (j < STR) && is_auto;
        exp_cnt[k]  = cnt;
        k++;
      end
    end
    model_cnt = int'(cnt);
  endtask

  task automatic fill_const(input int n, input int y, input int lvl, input bit falling);
    for (int k = 0; k < n; k++) begin
      s_y[k]     = 8'(y);
      s_lvl[k]   = 8'(lvl);
      s_slope[k] = falling;
      s_arm[k]   = (k != 0);
    end
  endtask

  task automatic fill_ramp(input int n);
    fill_const(n, 0, 64, 1'b0);
    for (int k = 0; k < n; k++) s_y[k] = 8'(k);
  endtask

  function automatic int fire_count(input int n);
    int c = 0;
    for (int k = 0; k < n; k++)
      if (got_trig[k] === 1'b1 && (k == 0 || got_trig[k-1] !== 1'b1)) c++;
    return c;
  endfunction

  function automatic int min_spacing(input int n);
    int last = -1;
    int best = 1 << 30;
    for (int k = 0; k < n; k++) begin
      if (got_trig[k] === 1'b1 && (k == 0 || got_trig[k-1] !== 1'b1)) begin
        if (last >= 0 && k - last < best) best = k - last;
        last = k;
      end
    end
    return best;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    arm = 1'b0;
    repeat (3) @(posedge clk_62_5);
    #1;
    checks++;
    if (trigger !== 1'b0) begin errors++; $display("[TB] FAIL reset_trigger: got %b, expected 0", trigger); end
    checks++;
    if (auto_fired !== 1'b0) begin errors++; $display("[TB] FAIL reset_auto: got %b, expected 0", auto_fired); end
    checks++;
    if (trig_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d, expected 0", trig_count); end
    rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_rising_ramp;
    int n = 128;
    int high = 0;
    fill_ramp(n);
    run_cycles(n);
    model_run(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
        errors++;
        $display("[TB] FAIL ramp_trace cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                 k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
        break;
      end
    end
    for (int k = 0; k < n; k++) if (got_trig[k] === 1'b1) high++;
    checks++;
    if (got_trig[66] !== 1'b1 || got_trig[65] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ramp_latency: trigger at 65/66 = %b/%b, expected 0/1", got_trig[65], got_trig[66]);
    end
    checks++;
    if (high != STR) begin errors++; $display("[TB] FAIL ramp_width: got %0d high cycles, expected %0d", high, STR); end
    checks++;
    if (got_cnt[n-1] !== 8'd1) begin errors++; $display("[TB] FAIL ramp_count: got %0d, expected 1", got_cnt[n-1]); end
  endtask

  task automatic test_hysteresis;
    int n = 80;
    fill_const(n, 66, 64, 1'b0);
    for (int k = 0; k < 40; k++) s_y[k] = (k % 2 == 1) ? 8'd66 : 8'd62;
    s_y[40] = 8'd59;
    run_cycles(n);
    model_run(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
        errors++;
        $display("[TB] FAIL hyst_trace cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                 k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
        break;
      end
    end
    checks++;
    if (fire_count(n) != 1 || got_trig[43] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hyst_fire: got %0d fires (trigger@43=%b), expected 1 fire at 43", fire_count(n), got_trig[43]);
    end
  endtask

  task automatic test_holdoff;
    int n = 600;
    fill_const(n, 0, 64, 1'b0);
    for (int k = 0; k < n; k++) s_y[k] = ((k / 10) % 2 == 1) ? 8'd100 : 8'd0;
    run_cycles(n);
    model_run(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
        errors++;
        $display("[TB] FAIL holdoff_trace cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                 k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
        break;
      end
    end
    checks++;
    if (fire_count(n) != 4) begin errors++; $display("[TB] FAIL holdoff_fires: got %0d, expected 4", fire_count(n)); end
    checks++;
    if (min_spacing(n) < STR + HOLD + 16) begin
      errors++;
      $display("[TB] FAIL holdoff_spacing: got %0d cycles, expected at least %0d", min_spacing(n), STR + HOLD + 16);
    end
  endtask

  task automatic test_abort;
    int n = 120;
    int base = model_cnt;
    fill_ramp(n);
    for (int k = 67; k < 90; k++) s_arm[k] = 1'b0;
    for (int k = 90; k < n; k++) s_y[k] = (k < 100) ? 8'd0 : 8'd80;
    run_cycles(n);
    model_run(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
        errors++;
        $display("[TB] FAIL abort_trace cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                 k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
        break;
      end
    end
    checks++;
    if (got_trig[66] !== 1'b1 || got_trig[67] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_drop: trigger at 66/67 = %b/%b, expected 1/0", got_trig[66], got_trig[67]);
    end
    checks++;
    if (got_cnt[89] !== 8'(base + 1)) begin
      errors++;
      $display("[TB] FAIL abort_count: got %0d, expected %0d", got_cnt[89], 8'(base + 1));
    end
    checks++;
    if (got_trig[102] !== 1'b1) begin errors++; $display("[TB] FAIL abort_rearm: trigger@102 got %b, expected 1", got_trig[102]); end
  endtask

  task automatic test_auto;
    int n = 2300;
    fill_const(n, 10, 64, 1'b0);
    run_cycles(n);
    model_run(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
        errors++;
        $display("[TB] FAIL auto_trace cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                 k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
        break;
      end
    end
    checks++;
    if (fire_count(n) != (AUTO_EN ? 2 : 0)) begin
      errors++;
      $display("[TB] FAIL auto_fires: got %0d, expected %0d", fire_count(n), AUTO_EN ? 2 : 0);
    end
    checks++;
    if (got_trig[1 + TMO] !== AUTO_EN || got_auto[1 + TMO] !== AUTO_EN || got_trig[1 + 2 * TMO + STR + HOLD] !== AUTO_EN) begin
      errors++;
      $display("[TB] FAIL auto_timing: trig/auto at first fire %b/%b, trig at second %b, expected %b",
               got_trig[1 + TMO], got_auto[1 + TMO], got_trig[1 + 2 * TMO + STR + HOLD], AUTO_EN);
    end
  endtask

  task automatic test_edge_levels;
    int n = 300;
    for (int pass = 0; pass < 2; pass++) begin
      fill_const(n, 0, (pass == 0) ? 0 : 255, pass == 1);
      for (int k = 0; k < n; k++) s_y[k] = 8'($urandom_range(0, 255));
      run_cycles(n);
      model_run(n);
      for (int k = 0; k < n; k++) begin
        checks++;
        if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
          errors++;
          $display("[TB] FAIL edge_level%0d_trace cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                   pass, k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
          break;
        end
      end
      checks++;
      if (fire_count(n) != 0) begin errors++; $display("[TB] FAIL edge_level%0d_fires: got %0d, expected 0", pass, fire_count(n)); end
    end
  endtask

  task automatic test_random;
    int n = 500;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < n; k++) begin
        s_y[k]     = 8'($urandom_range(0, 255));
        s_lvl[k]   = 8'($urandom_range(20, 235));
        s_slope[k] = 1'($urandom_range(0, 1));
        s_arm[k]   = (k != 0) && ($urandom_range(0, 63) != 0);
      end
      run_cycles(n);
      model_run(n);
      for (int k = 0; k < n; k++) begin
        checks++;
        if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
          errors++;
          $display("[TB] FAIL random%0d_trace cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                   it, k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
          break;
        end
      end
    end
  endtask

  task automatic test_async_reset;
    fill_ramp(68);
    run_cycles(68);
    checks++;
    if (got_trig[67] !== 1'b1) begin errors++; $display("[TB] FAIL async_setup: trigger@67 got %b, expected 1", got_trig[67]); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (trigger !== 1'b0) begin errors++; $display("[TB] FAIL async_trigger: got %b, expected 0", trigger); end
    checks++;
    if (trig_count !== 8'd0) begin errors++; $display("[TB] FAIL async_count: got %0d, expected 0", trig_count); end
    @(posedge clk_62_5);
    #1;
    rst = 1'b0;
    model_cnt = 0;
    fill_const(6, 200, 64, 1'b0);
    for (int k = 0; k < 6; k++) s_arm[k] = 1'b0;
    run_cycles(6);
    model_run(6);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({got_trig[k], got_auto[k], got_cnt[k]} !== {exp_trig[k], exp_auto[k], exp_cnt[k]}) begin
        errors++;
        $display("[TB] FAIL async_idle cycle %0d: trig/auto/count %b/%b/%0d, expected %b/%b/%0d",
                 k, got_trig[k], got_auto[k], got_cnt[k], exp_trig[k], exp_auto[k], exp_cnt[k]);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rising_ramp();
    test_hysteresis();
    test_holdoff();
    test_abort();
    test_auto();
    test_edge_levels();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trigger_detect.md
TRIGGER_DETECT -- requirements
Module: trigger_detect

Interface
REQ-001 Parameter HYST, default 4: hysteresis band in sample codes.
REQ-002 Parameter HOLDOFF_CYCLES, default 160: clk_62_5 cycles of dead time after each fire; 0 disables holdoff.
REQ-003 Parameter STRETCH, default 4: trigger pulse width in clk_62_5 cycles; minimum 3.
REQ-004 Parameter AUTO_TIMEOUT, default 625000: cycles without a crossing before an auto-fire.
REQ-005 Port clk_62_5, input, 1: the single block clock, sampled on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port in_y, input, 8: unsigned compressor sample, one per cycle.
REQ-008 Port level, input, 8: unsigned trigger threshold.
REQ-009 Port slope_sel, input, 1: 0 selects rising edge, 1 selects falling edge.
REQ-010 Port arm, input, 1: enables detection while high.
REQ-011 Port trigger, output, 1: registered fire pulse to the oscilloscope stage.
REQ-012 Port auto_fired, output, 1: high together with trigger when the fire came from the timeout.
REQ-013 Port trig_count, output, 8: count of fires, wrapping 255 to 0.

Function
REQ-014 in_y shall be registered once into sample_q; all comparisons shall use sample_q.
REQ-015 The FSM states shall be IDLE, ARMING, READY, FIRE and HOLDOFF.
REQ-016 IDLE: trigger=0; when arm=1 the FSM shall move to ARMING and latch level into level_q and slope_sel into slope_q.
REQ-017 ARMING, rising: the FSM shall move to READY when sample_q < level_q-HYST, with the subtraction saturating at 0.
REQ-018 ARMING, falling: the FSM shall move to READY when sample_q > level_q+HYST, with the addition saturating at 255.
REQ-019 READY: the FSM shall move to FIRE when sample_q >= level_q (rising) or sample_q <= level_q (falling).
REQ-020 Latency: a crossing sample presented on in_y before edge N shall give trigger=1 after edge N+2.
REQ-021 FIRE: trigger shall stay high for exactly STRETCH cycles, then the FSM shall go to HOLDOFF, or to ARMING if HOLDOFF_CYCLES=0.
REQ-022 Entry to FIRE shall increment trig_count by 1, wrapping modulo 256.
REQ-023 HOLDOFF: the FSM shall count HOLDOFF_CYCLES cycles, then go to ARMING and re-latch level and slope_sel.
REQ-024 Crossings during FIRE or HOLDOFF shall be ignored, with no queueing.
REQ-025 arm=0 in any state shall force IDLE on the next edge; trigger shall drop on that edge even mid-stretch; trig_count shall be kept.
REQ-026 level or slope_sel changes after latching shall take effect only at the next ARMING entry.
REQ-027 level=0 with rising slope: ARMING shall never pass because nothing is < 0, so only an auto-fire can occur.
REQ-028 level=255 with falling slope: ARMING shall likewise never pass.
REQ-029 trigger and auto_fired shall be direct register outputs, with no combinational path from any input.

Reset
REQ-030 rst=1 shall immediately force state=IDLE, trigger=0, auto_fired=0, trig_count=0, sample_q=0, level_q=0, slope_q=0 and all counters to 0.
REQ-031 Reset asserted mid-FIRE shall drop trigger asynchronously; after release the FSM shall wait in IDLE for arm.

Configuration
REQ-032 The macro TRIGGER_AUTO_EN shall compile the auto-trigger function in or out.
REQ-033 With TRIGGER_AUTO_EN defined: a timeout counter shall clear on ARMING entry and count in ARMING and READY; reaching AUTO_TIMEOUT shall force FIRE with auto_fired=1 for the whole stretch.
REQ-034 A genuine crossing on the same cycle as the timeout shall win, giving auto_fired=0.
REQ-035 Without TRIGGER_AUTO_EN: the timeout counter shall be absent, auto_fired shall be tied to 0, and the block shall wait indefinitely for a crossing.

Verification
REQ-036 Rising ramp: level=64, slope_sel=0, arm=1, in_y ramps 0..127 by 1 per cycle -> one 4-cycle trigger 2 cycles after in_y=64; trig_count=1.
REQ-037 Hysteresis noise: level=64, in_y alternates 62/66 -> no fire; then a dip to 59 followed by 66 -> one fire.
REQ-038 Holdoff: square wave 0/100, period 20 cycles, HOLDOFF_CYCLES=160 -> fire spacing of 180 cycles or more; trig_count advances 1 per interval.
REQ-039 Abort: arm dropped on the second cycle of FIRE -> trigger low on the next edge; no HOLDOFF; trig_count unchanged afterwards.
REQ-040 Auto, TRIGGER_AUTO_EN defined, AUTO_TIMEOUT=1000: constant in_y=10, level=64 -> trigger with auto_fired=1 every 1000+STRETCH+HOLDOFF cycles; macro undefined -> trigger never fires.
REQ-041 Async reset: assert rst between clock edges while trigger=1 -> trigger=0 and trig_count=0 before the next edge.
